// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared types and constants for the I2C single-master sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  // Transfer sequencer states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    READ     = 3'd4,
    MACK     = 3'd5,
    STOP     = 3'd6
  } state_t;

  // Quarter phases of one SCL bit period
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } phase_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // SCL is low in the first half of a bit and high in the second half
  function automatic logic scl_level(input phase_t p);
    return (p == Q2) || (p == Q3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_scl_gen.sv
// ============================================================================
// Module : i2c_scl_gen
// Brief  : Quarter-period timebase. Counts clk cycles per SCL quarter, steps
//          the phase Q0..Q3 and provides sample / bit-end strobes plus the
//          nominal SCL level of the upcoming phase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int SCL_QUARTER = 125
) (
  input  logic   clk,
  input  logic   rst_,          // synchronous, active-low (includes soft reset)
  output phase_t o_phase_nxt,   // phase that takes effect at the next edge
  output logic   o_scl_nxt,     // SCL level belonging to o_phase_nxt
  output logic   o_sample,      // last clk of Q2: sample SDA
  output logic   o_bit_end      // last clk of Q3: bit boundary
);

  localparam int CW = (SCL_QUARTER > 1) ? $clog2(SCL_QUARTER) : 1;

  logic [CW-1:0] r_qcnt;
  phase_t        r_phase;
  logic          w_qend;
  phase_t        w_phase_nxt;

  assign w_qend = (r_qcnt == CW'(SCL_QUARTER - 1));

  // Next phase: advance one quarter when the counter wraps
  always_comb begin
    w_phase_nxt = r_phase;
    if (w_qend) begin
      case (r_phase)
        Q0:      w_phase_nxt = Q1;
        Q1:      w_phase_nxt = Q2;
        Q2:      w_phase_nxt = Q3;
        Q3:      w_phase_nxt = Q0;
        default: w_phase_nxt = Q0;
      endcase
    end
  end

  // Quarter counter and phase register
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_qcnt  <= '0;
      r_phase <= Q0;
    end else begin
      r_qcnt  <= w_qend ? '0 : r_qcnt + CW'(1);
      r_phase <= w_phase_nxt;
    end
  end

  assign o_phase_nxt = w_phase_nxt;
  assign o_scl_nxt   = scl_level(w_phase_nxt);
  assign o_sample    = w_qend && (r_phase == Q2);
  assign o_bit_end   = w_qend && (r_phase == Q3);

endmodule

`default_nettype wire

// File: rtl/fsm_master.sv
// ============================================================================
// Module : fsm_master
// Brief  : I2C single-master bit/byte sequencer. START, address byte, slave
//          ACK, optional byte reads with master ACK/NACK, STOP. All state
//          changes happen at bit boundaries; outputs are registered and are
//          decoded from next-state/next-phase so they align with the timebase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fsm_master
  import i2c_pkg::*;
#(
  parameter int SCL_QUARTER = 125
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       sda_in,
  input  logic       fsm_select_,
  input  logic [7:0] reset_register,
  input  logic [7:0] control_reg,
  output logic       scl_out,
  output logic       sda_out,
  output logic       sda_select
);

  logic       w_rst_n;
  phase_t     w_phase_nxt;
  logic       w_scl_lvl;
  logic       w_sample;
  logic       w_bit_end;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_tx;
  logic [7:0] w_tx_nxt;
  logic       r_rw;
  logic [2:0] r_bitcnt;
  logic       r_ack;
  logic [7:0] r_rx;
  logic       r_mack_nack;
  logic       w_mack_nack_nxt;
  logic       w_start_go;
  logic       w_read_last;
  logic       w_scl_nxt;
  logic       w_sda_nxt;
  logic       w_sel_nxt;

  // Hard and soft reset share one path
  assign w_rst_n = rst_ && (reset_register == 8'h00);

  i2c_scl_gen #(
    .SCL_QUARTER (SCL_QUARTER)
  ) u_scl_gen (
    .clk         (clk),
    .rst_        (w_rst_n),
    .o_phase_nxt (w_phase_nxt),
    .o_scl_nxt   (w_scl_lvl),
    .o_sample    (w_sample),
    .o_bit_end   (w_bit_end)
  );

  // IDLE is always entered on a bit boundary (or from reset with the timebase
  // cleared), so leaving it at the next bit end guarantees a full bus-free
  // SCL period after STOP.
  assign w_start_go  = (r_state == IDLE) && w_bit_end && !fsm_select_;
  assign w_read_last = (r_state == READ) && w_bit_end && (r_bitcnt == 3'd7);

  // Next-state decode; transitions only at bit boundaries
  always_comb begin
    w_state_nxt = r_state;
    if (w_bit_end) begin
      case (r_state)
        IDLE:     if (!fsm_select_) w_state_nxt = START;
        START:    w_state_nxt = ADDR;
        ADDR:     if (r_bitcnt == 3'd7) w_state_nxt = ADDR_ACK;
        ADDR_ACK: w_state_nxt = (r_ack == ACK && r_rw) ? READ : STOP;
        READ:     if (r_bitcnt == 3'd7) w_state_nxt = MACK;
        MACK:     w_state_nxt = (r_mack_nack == NACK) ? STOP : READ;
        STOP:     w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the transmit shifter and the master-ACK decision
  always_comb begin
    w_tx_nxt = r_tx;
    if (w_start_go) begin
      w_tx_nxt = control_reg;
    end else if ((r_state == ADDR) && w_bit_end) begin
      w_tx_nxt = {r_tx[6:0], 1'b0};
    end
    w_mack_nack_nxt = w_read_last ? fsm_select_ : r_mack_nack;
  end

  // Pad-level decode for the state/phase that begins at the next edge
  always_comb begin
    w_scl_nxt = 1'b1;
    w_sda_nxt = 1'b1;
    w_sel_nxt = 1'b1;
    case (w_state_nxt)
      IDLE: begin
      end
      START: begin
        w_sda_nxt = (w_phase_nxt == Q0) || (w_phase_nxt == Q1);
      end
      ADDR: begin
        w_scl_nxt = w_scl_lvl;
        w_sda_nxt = w_tx_nxt[7];
      end
      ADDR_ACK, READ: begin
        w_scl_nxt = w_scl_lvl;
        w_sel_nxt = 1'b0;
      end
      MACK: begin
        w_scl_nxt = w_scl_lvl;
        w_sda_nxt = w_mack_nack_nxt;
      end
      STOP: begin
        w_scl_nxt = w_scl_lvl;
        w_sda_nxt = (w_phase_nxt == Q3);
      end
      default: begin
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: address latch/shift, bit counter, ACK and read-data sampling
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      r_tx        <= 8'h00;
      r_rw        <= 1'b0;
      r_bitcnt    <= 3'd0;
      r_ack       <= NACK;
      r_rx        <= 8'h00;
      r_mack_nack <= NACK;
    end else begin
      r_tx        <= w_tx_nxt;
      r_mack_nack <= w_mack_nack_nxt;
      if (w_start_go) begin
        r_rw <= control_reg[0];
      end
      if (((r_state == ADDR) || (r_state == READ)) && w_bit_end) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_sample && (r_state == ADDR_ACK)) begin
        r_ack <= sda_in;
      end
      if (w_sample && (r_state == READ)) begin
        r_rx <= (r_rx << 1) | {7'd0, sda_in};
      end
    end
  end

  // Registered pad outputs
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      scl_out    <= 1'b1;
      sda_out    <= 1'b1;
      sda_select <= 1'b1;
    end else begin
      scl_out    <= w_scl_nxt;
      sda_out    <= w_sda_nxt;
      sda_select <= w_sel_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fsm_master.sv
// ============================================================================
// Module : tb_fsm_master
// Brief  : Directed self-checking bench for fsm_master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fsm_master;

  localparam int Q   = 5;
  localparam int BIT = 4 * Q;

  logic       clk = 1'b0;
  logic       rst_;
  logic       sda_in;
  logic       fsm_select_;
  logic [7:0] reset_register;
  logic [7:0] control_reg;
  logic       scl_out;
  logic       sda_out;
  logic       sda_select;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         t_stop  = 0;
  logic [7:0] byte_v;
  logic [7:0] rdata;
  logic       ok;

  fsm_master #(
    .SCL_QUARTER (Q)
  ) dut (
    .clk            (clk),
    .rst_           (rst_),
    .sda_in         (sda_in),
    .fsm_select_    (fsm_select_),
    .reset_register (reset_register),
    .control_reg    (control_reg),
    .scl_out        (scl_out),
    .sda_out        (sda_out),
    .sda_select     (sda_select)
  );

  always #5 clk = ~clk;

  // Cycle counter for interval measurements
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for scl_out to change to lvl (bounded)
  task automatic wait_scl(input logic lvl, input string tag);
    logic prev;
    logic found;
    int   n;
    prev  = scl_out;
    found = 1'b0;
    n     = 0;
    while (!found && n < 4 * BIT) begin
      tick();
      n++;
      if (prev !== lvl && scl_out === lvl) found = 1'b1;
      prev = scl_out;
    end
    if (!found) chk(tag, {31'd0, found}, 32'd1);
  endtask

  // Wait for sda_out to change to lvl (bounded)
  task automatic wait_sda(input logic lvl, input string tag);
    logic prev;
    logic found;
    int   n;
    prev  = sda_out;
    found = 1'b0;
    n     = 0;
    while (!found && n < 8 * BIT) begin
      tick();
      n++;
      if (prev !== lvl && sda_out === lvl) found = 1'b1;
      prev = sda_out;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_           = 1'b0;
    reset_register = 8'h00;
    control_reg    = 8'h00;
    fsm_select_    = 1'b1;
    sda_in         = 1'b1;

    // Hard reset
    tick(); tick();
    chk("rst_scl", scl_out, 1);
    chk("rst_sda", sda_out, 1);
    chk("rst_sel", sda_select, 1);

    // Soft reset holds IDLE even with a transfer requested
    rst_           = 1'b1;
    reset_register = 8'hCC;
    fsm_select_    = 1'b0;
    control_reg    = 8'h55;
    ok = 1'b1;
    repeat (2 * BIT) begin
      tick();
      if ({scl_out, sda_out, sda_select} !== 3'b111) ok = 1'b0;
    end
    chk("softrst_hold", ok, 1);
    reset_register = 8'h00;

    // START then address 0x55 (read)
    wait_sda(0, "start1_seen");
    chk("start1_scl_high", scl_out, 1);
    for (int i = 0; i < 8; i++) begin
      wait_scl(1, "addr1_rise");
      byte_v = {byte_v[6:0], sda_out};
      chk("addr1_sel", sda_select, 1);
    end
    chk("addr1_byte", byte_v, 8'h55);

    // Slave ACK
    wait_scl(0, "ack1_fall");
    sda_in = 1'b0;
    wait_scl(1, "ack1_rise");
    chk("ack1_sel", sda_select, 0);

    // Read 0xA5, master ACK
    rdata = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      wait_scl(0, "rd1_fall");
      sda_in = rdata[7 - i];
      wait_scl(1, "rd1_rise");
      chk("rd1_sel", sda_select, 0);
    end
    wait_scl(0, "mack1_fall");
    sda_in = 1'b1;
    wait_scl(1, "mack1_rise");
    chk("mack1_sel", sda_select, 1);
    chk("mack1_sda_ack", sda_out, 0);
    chk("rx_a5", dut.r_rx, 8'hA5);

    // Read 0x3C, deselect mid-byte -> master NACK
    rdata = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      wait_scl(0, "rd2_fall");
      sda_in = rdata[7 - i];
      if (i == 2) fsm_select_ = 1'b1;
      wait_scl(1, "rd2_rise");
    end
    wait_scl(0, "mack2_fall");
    sda_in = 1'b1;
    wait_scl(1, "mack2_rise");
    chk("mack2_sel", sda_select, 1);
    chk("mack2_sda_nack", sda_out, 1);
    chk("rx_3c", dut.r_rx, 8'h3C);

    // STOP
    wait_scl(0, "stop1_fall");
    wait_scl(1, "stop1_rise");
    chk("stop1_sda_low", sda_out, 0);
    chk("stop1_sel", sda_select, 1);
    wait_sda(1, "stop1_sda_rise");
    chk("stop1_scl_high", scl_out, 1);
    t_stop      = cyc;
    fsm_select_ = 1'b0;
    control_reg = 8'hA0;

    // Bus stays idle for a full SCL period even though a transfer is requested
    ok = 1'b1;
    repeat (5 * Q) begin
      tick();
      if ({scl_out, sda_out, sda_select} !== 3'b111) ok = 1'b0;
    end
    chk("idle_after_stop", ok, 1);

    // Next START (address 0xA0, slave NACKs)
    wait_sda(0, "start2_seen");
    chk("start2_scl_high", scl_out, 1);
    chk("start2_gap", {31'd0, (cyc - t_stop) >= 7 * Q}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      wait_scl(1, "addr2_rise");
      byte_v = {byte_v[6:0], sda_out};
    end
    chk("addr2_byte", byte_v, 8'hA0);
    wait_scl(0, "ack2_fall");
    sda_in = 1'b1;
    wait_scl(1, "ack2_rise");
    chk("ack2_sel", sda_select, 0);
    wait_scl(0, "stop2_fall");
    wait_scl(1, "stop2_rise");
    chk("stop2_sda_low", sda_out, 0);
    wait_sda(1, "stop2_sda_rise");
    chk("stop2_scl_high", scl_out, 1);
    control_reg = 8'h00;

    // Soft reset mid-address: IDLE outputs on the next clk, no STOP
    wait_sda(0, "start3_seen");
    for (int i = 0; i < 3; i++) wait_scl(1, "addr3_rise");
    wait_scl(0, "addr3_fall");
    tick(); tick();
    chk("pre_rst_scl", scl_out, 0);
    chk("pre_rst_sda", sda_out, 0);
    reset_register = 8'h01;
    tick();
    chk("midrst_out", {scl_out, sda_out, sda_select}, 3'b111);
    ok = 1'b1;
    repeat (BIT) begin
      tick();
      if ({scl_out, sda_out, sda_select} !== 3'b111) ok = 1'b0;
    end
    chk("midrst_hold", ok, 1);
    fsm_select_    = 1'b1;
    reset_register = 8'h00;
    tick();
    chk("final_idle", {scl_out, sda_out, sda_select}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
